apb_slave_responder: RTL and testbench



---
 rtl/apb_slave_responder_if.sv | 27 ++
 rtl/apb_slave_responder.sv | 138 +++++++++++++
 tb/tb_apb_slave_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_responder_if
// Brief    : APB completer bus bundle (bridge side = master, responder = slave)
// Revision : 1.0
// ============================================================================
interface apb_slave_responder_if;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_responder
// Brief    : APB completer with four register banks, wait states, error and
//            protocol-violation detection
// Revision : 1.0
// ============================================================================
module apb_slave_responder #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int AW          = 12
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    apb_slave_responder_if.slave  bus,
    output logic                  prot_err
);

    localparam int          c_ww    = $clog2(DEPTH);
    localparam int          c_iw    = AW - 2;
    localparam logic [c_iw:0] c_depth = (c_iw + 1)'(DEPTH);
    localparam logic [3:0]  c_ws    = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    logic [3:0]          r_sel;
    logic [AW-1:0]       r_addr;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [c_ww+1:0]     r_idx;
    logic [3:0]          r_cnt;
    logic [31:0]         r_prdata;
    logic                r_prot_err;
    logic [31:0]         r_mem [4*DEPTH];

    logic [c_iw-1:0]     w_word_full;
    logic [c_ww-1:0]     w_word;
    logic [1:0]          w_bank;
    logic [c_ww+1:0]     w_idx;
    logic                w_onehot;
    logic                w_oor;
    logic                w_err;
    logic                w_mismatch;
    logic                w_pready;

    assign w_word_full = bus.Paddr[AW-1:2];
    assign w_word      = bus.Paddr[c_ww+1:2];
    assign w_onehot    = (bus.Pselx != 4'd0) && ((bus.Pselx & (bus.Pselx - 4'd1)) == 4'd0);
    assign w_oor       = ({1'b0, w_word_full} >= c_depth);
    assign w_err       = !w_onehot || (bus.Paddr[1:0] != 2'd0) || w_oor;
    assign w_idx       = {w_bank, w_word};

    always_comb begin
        w_bank = 2'd0;
        case (bus.Pselx)
            4'b0010: w_bank = 2'd1;
            4'b0100: w_bank = 2'd2;
            4'b1000: w_bank = 2'd3;
            default: w_bank = 2'd0;
        endcase
    end

    // Any change to the captured transfer while in ACCESS is a violation.
    assign w_mismatch = (bus.Pselx != r_sel) || (bus.Paddr[AW-1:0] != r_addr) ||
                        (bus.Pwrite != r_write) || (bus.Pwdata != r_wdata);

    assign w_pready    = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign bus.Pready  = w_pready;
    assign bus.Pslverr = w_pready && r_err;
    assign bus.Prdata  = r_prdata;
    assign prot_err    = r_prot_err;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state    <= IDLE;
            r_sel      <= 4'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= 32'd0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= 4'd0;
            r_prdata   <= 32'd0;
            r_prot_err <= 1'b0;
            for (int i = 0; i < 4*DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.Penable) begin
                        r_prot_err <= 1'b1;
                    end else if (bus.Pselx != 4'd0) begin
                        r_sel   <= bus.Pselx;
                        r_addr  <= bus.Paddr[AW-1:0];
                        r_write <= bus.Pwrite;
                        r_wdata <= bus.Pwdata;
                        r_err   <= w_err;
                        r_idx   <= w_idx;
                        r_cnt   <= c_ws;
                        r_state <= ACCESS;
                        if (!bus.Pwrite) begin
                            r_prdata <= w_err ? 32'd0 : r_mem[w_idx];
                        end
                    end
                end
                ACCESS: begin
                    if (w_mismatch) begin
                        r_prot_err <= 1'b1;
                    end
                    if (r_cnt == 4'd0) begin
                        // Completion is already signalled, so it finishes on captured values.
                        if (!bus.Penable) begin
                            r_prot_err <= 1'b1;
                        end
                        if (r_write && !r_err) begin
                            r_mem[r_idx] <= r_wdata;
                        end
                        r_state <= IDLE;
                    end else if (!bus.Penable || (bus.Pselx == 4'd0)) begin
                        r_prot_err <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_responder
// Brief    : Self-checking bench: three responders (0/3/2 wait states)
// Revision : 1.0
// ============================================================================
module tb_apb_slave_responder;

    logic        Hclk = 1'b0;
    logic        Hreset;
    int          dsel;
    logic [3:0]  psel;
    logic        pen;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pe0, pe3, pe2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vt[16];

    always #5 Hclk = ~Hclk;

    apb_slave_responder_if if0 ();
    apb_slave_responder_if if3 ();
    apb_slave_responder_if if2 ();

    // Only the selected responder sees a select/enable; the others stay idle.
    assign if0.Pselx   = (dsel == 0) ? psel : 4'd0;
    assign if0.Penable = (dsel == 0) && pen;
    assign if0.Pwrite  = pwrite;
    assign if0.Paddr   = paddr;
    assign if0.Pwdata  = pwdata;
    assign if3.Pselx   = (dsel == 3) ? psel : 4'd0;
    assign if3.Penable = (dsel == 3) && pen;
    assign if3.Pwrite  = pwrite;
    assign if3.Paddr   = paddr;
    assign if3.Pwdata  = pwdata;
    assign if2.Pselx   = (dsel == 2) ? psel : 4'd0;
    assign if2.Penable = (dsel == 2) && pen;
    assign if2.Pwrite  = pwrite;
    assign if2.Paddr   = paddr;
    assign if2.Pwdata  = pwdata;

    apb_slave_responder #(.DEPTH(16), .WAIT_STATES(0), .AW(12)) u0 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(if0), .prot_err(pe0));
    apb_slave_responder #(.DEPTH(16), .WAIT_STATES(3), .AW(12)) u3 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(if3), .prot_err(pe3));
    apb_slave_responder #(.DEPTH(16), .WAIT_STATES(2), .AW(12)) u2 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(if2), .prot_err(pe2));

    logic [31:0] w_prdata;
    logic        w_pready, w_pslverr, w_prot;
    always_comb begin
        w_prdata  = if0.Prdata;
        w_pready  = if0.Pready;
        w_pslverr = if0.Pslverr;
        w_prot    = pe0;
        if (dsel == 3) begin
            w_prdata = if3.Prdata; w_pready = if3.Pready; w_pslverr = if3.Pslverr; w_prot = pe3;
        end else if (dsel == 2) begin
            w_prdata = if2.Prdata; w_pready = if2.Pready; w_pslverr = if2.Pslverr; w_prot = pe2;
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input int d, input logic wr, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input string name);
        sb_t e;
        int  lat;
        bit  done;
        e.wr = wr; e.rdata = exp_rd; e.err = exp_err;
        sbq.push_back(e);
        dsel = d; psel = sel; pen = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        tick();
        pen  = 1'b1;
        lat  = 1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            lat++;
            if (w_pready) begin
                e = sbq.pop_front();
                chk({name, " pslverr"}, 32'(w_pslverr), 32'(e.err));
                if (!e.wr) chk({name, " prdata"}, w_prdata, e.rdata);
                chk({name, " latency"}, lat, exp_lat);
                done = 1;
            end
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no Pready expected Pready within 40 cycles", name);
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
        psel = 4'd0;
        pen  = 1'b0;
    endtask

    initial begin
        Hreset = 1'b1; dsel = 0; psel = 4'd0; pen = 1'b0;
        pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;

        vt[0]  = '{1'b1, 4'b0010, 32'h008, 32'hA5A5_1234, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 4'b0010, 32'h008, 32'h0, 32'hA5A5_1234, 1'b0};
        vt[2]  = '{1'b1, 4'b0001, 32'h003, 32'h1111_1111, 32'h0, 1'b1};
        vt[3]  = '{1'b0, 4'b0001, 32'h000, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 4'b0001, 32'h003, 32'h0, 32'h0, 1'b1};
        vt[5]  = '{1'b1, 4'b0001, 32'h040, 32'h2222_2222, 32'h0, 1'b1};
        vt[6]  = '{1'b0, 4'b0001, 32'h000, 32'h0, 32'h0, 1'b0};
        vt[7]  = '{1'b1, 4'b0110, 32'h00C, 32'h3333_3333, 32'h0, 1'b1};
        vt[8]  = '{1'b0, 4'b0010, 32'h00C, 32'h0, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 4'b0100, 32'h00C, 32'h0, 32'h0, 1'b0};
        vt[10] = '{1'b1, 4'b1000, 32'h014, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vt[11] = '{1'b0, 4'b1000, 32'h014, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vt[12] = '{1'b0, 4'b0010, 32'hFFFF_F008, 32'h0, 32'hA5A5_1234, 1'b0};
        vt[13] = '{1'b1, 4'b0100, 32'h03C, 32'h1234_5678, 32'h0, 1'b0};
        vt[14] = '{1'b0, 4'b0100, 32'h03C, 32'h0, 32'h1234_5678, 1'b0};
        vt[15] = '{1'b0, 4'b0100, 32'h040, 32'h0, 32'h0, 1'b1};

        repeat (3) tick();
        Hreset = 1'b0;
        tick();
        chk("reset pready0", 32'(if0.Pready), 32'd0);
        chk("reset pslverr0", 32'(if0.Pslverr), 32'd0);
        chk("reset prdata0", if0.Prdata, 32'd0);
        chk("reset prot0", 32'(pe0), 32'd0);
        chk("reset pready3", 32'(if3.Pready), 32'd0);
        chk("reset prot2", 32'(pe2), 32'd0);

        // Back-to-back transfers through the vector table, no idle cycles.
        for (int i = 0; i < 16; i++) begin
            do_xfer(0, vt[i].wr, vt[i].sel, vt[i].addr, vt[i].wdata,
                    vt[i].rdata, vt[i].err, 2, $sformatf("vec%0d", i));
        end
        chk("vec prot0 clean", 32'(pe0), 32'd0);

        // Access phase with no setup.
        dsel = 0; psel = 4'b0010; pen = 1'b1; paddr = 32'h008; pwrite = 1'b0;
        tick();
        chk("nosetup prot", 32'(w_prot), 32'd1);
        chk("nosetup pready", 32'(w_pready), 32'd0);
        psel = 4'd0; pen = 1'b0;
        tick();
        chk("nosetup pready2", 32'(w_pready), 32'd0);
        chk("nosetup sticky", 32'(w_prot), 32'd1);
        do_xfer(0, 1'b0, 4'b1000, 32'h014, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "after_nosetup");

        // Three wait states.
        do_xfer(3, 1'b0, 4'b0001, 32'h004, 32'h0, 32'h0, 1'b0, 5, "ws3 rd");
        do_xfer(3, 1'b1, 4'b0001, 32'h004, 32'h55AA_55AA, 32'h0, 1'b0, 5, "ws3 wr");
        do_xfer(3, 1'b0, 4'b0001, 32'h004, 32'h0, 32'h55AA_55AA, 1'b0, 5, "ws3 rdback");
        chk("ws3 prot clean", 32'(pe3), 32'd0);

        // Penable dropped mid-wait: abort without commit.
        dsel = 2; psel = 4'b0001; pen = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'hCAFE_F00D;
        tick();
        pen = 1'b1;
        chk("abort pready a", 32'(w_pready), 32'd0);
        tick();
        pen = 1'b0;
        chk("abort pready b", 32'(w_pready), 32'd0);
        tick();
        psel = 4'd0;
        chk("abort pready c", 32'(w_pready), 32'd0);
        chk("abort prot", 32'(w_prot), 32'd1);
        tick();
        chk("abort pready d", 32'(w_pready), 32'd0);
        do_xfer(2, 1'b0, 4'b0001, 32'h010, 32'h0, 32'h0, 1'b0, 4, "abort rdback");

        // Reset during the access phase of a write.
        dsel = 0; psel = 4'b0001; pen = 1'b0; pwrite = 1'b1; paddr = 32'h018; pwdata = 32'h7777_7777;
        tick();
        pen = 1'b1;
        Hreset = 1'b1;
        tick();
        Hreset = 1'b0; psel = 4'd0; pen = 1'b0;
        chk("rst pready", 32'(if0.Pready), 32'd0);
        chk("rst pslverr", 32'(if0.Pslverr), 32'd0);
        chk("rst prdata", if0.Prdata, 32'd0);
        chk("rst prot0", 32'(pe0), 32'd0);
        chk("rst prot2", 32'(pe2), 32'd0);
        tick();
        do_xfer(0, 1'b0, 4'b0001, 32'h018, 32'h0, 32'h0, 1'b0, 2, "rst rdback");
        do_xfer(0, 1'b1, 4'b0100, 32'h004, 32'h0BAD_CAFE, 32'h0, 1'b0, 2, "post rst wr");
        do_xfer(0, 1'b0, 4'b0100, 32'h004, 32'h0, 32'h0BAD_CAFE, 1'b0, 2, "post rst rd");
        chk("post rst prot", 32'(pe0), 32'd0);
        chk("scoreboard empty", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
